shift_add_mul: RTL and testbench
================================

Name: shift_add_mul

Overview:
- Sequential unsigned shift-and-add multiplier.
- Each cycle it issues one partial-product addition, a WIDTH-bit add with carry-out, into the multiplier datapath of the arithmetic library.
- It sits upstream of the library's WIDTH-bit adders. It produces their operand pairs cycle by cycle and consumes their sum and carry.
- Ports use a start/busy/done handshake for integration into the arithmetic test harness.

Parameters:
- WIDTH, 32, operand width in bits; legal range ≥ 2; product is 2*WIDTH bits.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  start request; sampled on the rising edge.
- i_multiplicand  input  WIDTH  operand A, unsigned; captured when start is accepted.
- i_multiplier  input  WIDTH  operand B, unsigned; captured when start is accepted.
- o_busy  output  1  high while a multiplication is in progress.
- o_done  output  1  one-cycle pulse; product is valid.
- o_product  output  2*WIDTH  A*B; held stable until the next accepted start.

Behaviour:
- Reset: one clock and one reset only.
  - Reset is asynchronous and active-low: i_rst_n low immediately clears all state.
  - During reset: state=IDLE, o_busy=0, o_done=0, o_product=0, count=0, internal registers 0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- State machine: IDLE, RUN, DONE.
  - IDLE: i_start=1 accepts the request.
    - Load hi=0, lo=B, mcand=A, count=0; go to RUN.
  - RUN, each cycle: if lo[0]=1, {c,sum} = hi + mcand (WIDTH-bit add, carry-out c); else c=0, sum=hi.
    - Then {hi,lo} <= {c,sum,lo[WIDTH-1:1]}, i.e. a right shift of the (2*WIDTH+1)-bit concatenation by one bit.
    - count increments. When count reaches WIDTH-1, go to DONE on the same edge as the last shift.
  - DONE: lasts exactly one cycle.
    - o_done=1, o_busy=0, o_product={hi,lo}.
    - If i_start=1 in DONE, the new operands are accepted: next state RUN (back-to-back). Otherwise next state is IDLE.
- Latency: start sampled at edge T.
  - o_busy=1 from T+1 through the cycle ending at edge T+WIDTH.
  - o_done=1 in the cycle following edge T+WIDTH, exactly WIDTH+1 edges after T.
- o_busy = (state==RUN).
- o_product updates only on entry to DONE. It is otherwise held, including across IDLE.
- i_start while in RUN is ignored: no queueing, no error.
- Operands are captured only at acceptance. Later changes on the input pins have no effect.
- Width rule: the accumulator needs WIDTH+1 bits, carried by c. The max product (2^WIDTH-1)^2 fits exactly in 2*WIDTH bits; no overflow output.
- count width = $clog2(WIDTH).

Optional Feature:
- Macro: SHIFT_ADD_MUL_ZERO_SKIP_EN.
- Defined: at acceptance, if A==0 or B==0, go directly to DONE with a forced product of 0.
  - o_done is high one edge after the start edge; o_busy stays 0 throughout.
- Undefined: zero operands take the full WIDTH-cycle path and produce 0 with normal latency.

Decomposition:
- Shared package (arith_pkg), containing:
  - state enum (IDLE, RUN, DONE);
  - default width constant 32;
  - helper function for count width.
- One natural sub-module: mul_step_adder.
  - Combinational WIDTH-bit add with carry-out, gated by lo[0].
  - Kept separate so the library's adder architectures (ripple, carry-increment, etc.) can be swapped in.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=32, A=3, B=5, start pulse at edge T → o_done high only after edge T+32, o_product=15, o_busy high for exactly 32 cycles.
- A=B=0xFFFFFFFF → o_product=0xFFFFFFFE00000001; checks the carry path on every step.
- Start A=7, B=9. Assert i_start with A=1, B=1 while busy → ignored, result 63, single done pulse.
- Start A=0x1234, B=0x10. Pull i_rst_n low at cycle 10 → outputs clear immediately, no o_done. After release, a new start with A=2, B=3 → 6.
- Hold i_start high with new operands A=4, B=4 during the DONE cycle of 6*7 → first result 42. The second operation is accepted immediately, and 16 is produced WIDTH+1 edges later.
- A=0, B=0xABCD, with the macro defined → o_done one edge after start, product 0, o_busy never high. Without the macro → o_done at WIDTH+1 edges, product 0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and constants: multiplier FSM states,
// default operand width and the iteration-counter width helper.
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Iteration counter must hold WIDTH-1; never narrower than one bit.
  function automatic int unsigned count_w(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_step_adder.sv
// One partial-product step of the shift-add multiplier: WIDTH-bit add with
// carry-out, applied only when the current multiplier bit is set.
module mul_step_adder #(
  parameter int unsigned WIDTH = arith_pkg::DEF_WIDTH
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  always_comb begin
    if (en_i) begin
      {carry_o, sum_o} = {1'b0, hi_i} + {1'b0, mcand_i};
    end else begin
      carry_o = 1'b0;
      sum_o   = hi_i;
    end
  end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// Optional macro SHIFT_ADD_MUL_ZERO_SKIP_EN: zero operands finish in one cycle.
module shift_add_mul
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned CW = count_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] shifted;

  mul_step_adder #(.WIDTH(WIDTH)) u_step (
    .en_i    (lo_q[0]),
    .hi_i    (hi_q),
    .mcand_i (mcand_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Carry re-enters as the new MSB, so the WIDTH+1-bit accumulator never overflows.
  assign shifted = {carry, sum, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (i_start) begin
          hi_d    = '0;
          lo_d    = i_multiplier;
          mcand_d = i_multiplicand;
          count_d = '0;
          state_d = ST_RUN;
`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
          if ((i_multiplicand == '0) || (i_multiplier == '0)) begin
            product_d = '0;
            state_d   = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        {hi_d, lo_d} = shifted;
        count_d      = count_q + 1'b1;
        if (count_q == LAST) begin
          product_d = shifted;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign o_busy    = (state_q == ST_RUN);
  assign o_done    = (state_q == ST_DONE);
  assign o_product = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: cycle-level behavioural model plus
// directed literal checks and a randomized run.
module tb_shift_add_mul;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  shift_add_mul #(.WIDTH(W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product)
  );

  // Model: an accepted request multiplies with '*', stays busy for W cycles,
  // then shows done for one cycle with the stored product.
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pend = '0;
  int             m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_prod <= '0;
      m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_prod <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
        if (a == '0 || b == '0) begin
          m_done <= 1'b1;
          m_prod <= '0;
        end else begin
          m_pend <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
          m_busy <= 1'b1;
          m_left <= W;
        end
`else
        m_pend <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m_busy <= 1'b1;
        m_left <= W;
`endif
      end
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {63'b0, busy}, {63'b0, m_busy});
      check("done", {63'b0, done}, {63'b0, m_done});
      check("product", product, m_prod);
    end
  end

  // Called at a negedge; start is sampled on the next rising edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb);
    start = 1'b1;
    a = ta;
    b = tb;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int nbusy, output logic [2*W-1:0] p);
    lat = 1;
    nbusy = 0;
    p = '0;
    while (!done && lat <= W + 6) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
    p = product;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  int lat, nb, cnt, exp_lat, exp_busy;
  logic [2*W-1:0] p;

  initial begin
    @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    issue(32'd3, 32'd5);
    wait_done(lat, nb, p);
    check("lat_3x5", 64'(lat), 64'(W + 1));
    check("busy_3x5", 64'(nb), 64'(W));
    check("prod_3x5", p, 64'd15);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, nb, p);
    check("prod_max", p, 64'hFFFF_FFFE_0000_0001);

    issue(32'd7, 32'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nb, p);
    check("prod_7x9_ignore", p, 64'd63);
    count_done(W + 3, cnt);
    check("single_done_7x9", 64'(cnt), 64'd0);

    issue(32'd6, 32'd7);
    wait_done(lat, nb, p);
    check("prod_6x7", p, 64'd42);
    issue(32'd4, 32'd4);
    wait_done(lat, nb, p);
    check("lat_b2b", 64'(lat), 64'(W + 1));
    check("prod_b2b", p, 64'd16);

    issue(32'h1234, 32'h10);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_product", product, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    count_done(W + 3, cnt);
    check("no_done_after_rst", 64'(cnt), 64'd0);
    issue(32'd2, 32'd3);
    wait_done(lat, nb, p);
    check("prod_2x3", p, 64'd6);

`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
    exp_lat = 1;
    exp_busy = 0;
`else
    exp_lat = W + 1;
    exp_busy = W;
`endif
    issue(32'd0, 32'hABCD);
    wait_done(lat, nb, p);
    check("lat_zero", 64'(lat), 64'(exp_lat));
    check("busy_zero", 64'(nb), 64'(exp_busy));
    check("prod_zero", p, 64'd0);

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0: begin a = '0; b = $urandom; end
        1: begin a = $urandom; b = '0; end
        2: begin a = '1; b = $urandom; end
        3: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
